saed32_32x4_port_arbiter: RTL and testbench

SAED32_32X4_PORT_ARBITER -- requirements
Module: saed32_32x4_port_arbiter

---
 rtl/saed32_32x4_port_arbiter.sv | 114 +++++++++++
 tb/tb_saed32_32x4_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saed32_32x4_port_arbiter.sv
// Round-robin arbiter mapping up to two of four requesters onto the two ports
// of a 32x4 dual-port SRAM each cycle, with read-data return routing.
module saed32_32x4_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ,
    input  logic [NREQ-1:0]     RWE,
    input  logic [NREQ*AW-1:0]  RA,
    input  logic [NREQ*DW-1:0]  RD,
    output logic [NREQ-1:0]     GNT,
    output logic [NREQ-1:0]     RVALID,
    output logic [NREQ*DW-1:0]  RQ,
    output logic [AW-1:0]       A0,
    output logic [AW-1:0]       A1,
    output logic [DW-1:0]       D0,
    output logic [DW-1:0]       D1,
    output logic                WE0,
    output logic                WE1,
    output logic                CE0,
    output logic                CE1,
    output logic [DW-1:0]       WEM0,
    output logic [DW-1:0]       WEM1,
    input  logic [DW-1:0]       Q0,
    input  logic [DW-1:0]       Q1
);

    logic [1:0]    ptr_q, ptr_d;
    logic          tag0_v_q, tag1_v_q;
    logic [1:0]    tag0_idx_q, tag1_idx_q;
    logic          g0_v, g1_v;
    logic [1:0]    g0_idx, g1_idx, cand;
    logic [AW-1:0] ra_s [NREQ];
    logic [DW-1:0] rd_s [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign ra_s[gi] = RA[AW*gi +: AW];
        assign rd_s[gi] = RD[DW*gi +: DW];
    end

    // Port 0 takes the first requester in scan order; port 1 takes the next
    // one that does not collide with it, skipping over colliding candidates.
    always_comb begin
        g0_v   = 1'b0;
        g1_v   = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        cand   = '0;
        if (!RST) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = ptr_q + 2'(k);
                if (REQ[cand]) begin
                    if (!g0_v) begin
                        g0_v   = 1'b1;
                        g0_idx = cand;
                    end else if (!g1_v &&
                                 !((ra_s[cand] == ra_s[g0_idx]) && (RWE[cand] || RWE[g0_idx]))) begin
                        g1_v   = 1'b1;
                        g1_idx = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (g1_v)
            ptr_d = g1_idx + 2'd1;
        else if (g0_v)
            ptr_d = g0_idx + 2'd1;
    end

    assign CE0  = g0_v;
    assign CE1  = g1_v;
    assign WE0  = g0_v && RWE[g0_idx];
    assign WE1  = g1_v && RWE[g1_idx];
    assign A0   = g0_v ? ra_s[g0_idx] : '0;
    assign A1   = g1_v ? ra_s[g1_idx] : '0;
    assign D0   = (g0_v && RWE[g0_idx]) ? rd_s[g0_idx] : '0;
    assign D1   = (g1_v && RWE[g1_idx]) ? rd_s[g1_idx] : '0;
    assign WEM0 = '1;
    assign WEM1 = '1;

    // Read tags remember which requester owns the data each port returns next cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q      <= '0;
            tag0_v_q   <= 1'b0;
            tag1_v_q   <= 1'b0;
            tag0_idx_q <= '0;
            tag1_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            tag0_v_q   <= g0_v && !RWE[g0_idx];
            tag1_v_q   <= g1_v && !RWE[g1_idx];
            tag0_idx_q <= g0_idx;
            tag1_idx_q <= g1_idx;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_return
        logic hit0, hit1;
        assign GNT[gi]          = (g0_v && (g0_idx == 2'(gi))) || (g1_v && (g1_idx == 2'(gi)));
        assign hit0             = tag0_v_q && (tag0_idx_q == 2'(gi));
        assign hit1             = tag1_v_q && (tag1_idx_q == 2'(gi));
        assign RVALID[gi]       = hit0 || hit1;
        assign RQ[DW*gi +: DW]  = hit0 ? Q0 : (hit1 ? Q1 : '0);
    end

endmodule

// File: tb/tb_saed32_32x4_port_arbiter.sv
// Bench for the dual-port SRAM arbiter: directed scenarios plus a randomized
// run against a scan-order reference model and a behavioural memory.
module tb_saed32_32x4_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, rwe, gnt, rvalid;
    logic [19:0] ra;
    logic [15:0] rd, rq;
    logic [4:0]  a0, a1;
    logic [3:0]  d0, d1, wem0, wem1, q0, q1;
    logic        we0, we1, ce0, ce1;

    int checks = 0;
    int errors = 0;

    logic [3:0] sram  [32];
    logic [3:0] mem_m [32];
    int p_m;

    saed32_32x4_port_arbiter #(.NREQ(4), .AW(5), .DW(4)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .RWE(rwe), .RA(ra), .RD(rd),
        .GNT(gnt), .RVALID(rvalid), .RQ(rq),
        .A0(a0), .A1(a1), .D0(d0), .D1(d1), .WE0(we0), .WE1(we1),
        .CE0(ce0), .CE1(ce1), .WEM0(wem0), .WEM1(wem1), .Q0(q0), .Q1(q1)
    );

    always #5 clk = ~clk;

    // Behavioural 32x4 dual-port SRAM, loaded with a known pattern on reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 32; a++) sram[a] <= 4'(a * 7 + 3);
        end else begin
            if (ce0) begin
                if (we0) sram[a0] <= d0;
                else     q0 <= sram[a0];
            end
            if (ce1) begin
                if (we1) sram[a1] <= d1;
                else     q1 <= sram[a1];
            end
        end
    end

    function automatic void reload_model();
        for (int a = 0; a < 32; a++) mem_m[a] = 4'(a * 7 + 3);
        p_m = 0;
    endfunction

    // Reference arbitration: walk requesters in round-robin order from p.
    function automatic void model_arb(input logic [3:0] r, input logic [3:0] w,
                                      input logic [19:0] a, input int p,
                                      output int w0, output int w1);
        w0 = -1;
        w1 = -1;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (p + k) % 4;
            if (r[c]) begin
                if (w0 < 0) w0 = c;
                else if (w1 < 0 && !((a[c*5 +: 5] == a[w0*5 +: 5]) && (w[c] || w[w0]))) w1 = c;
            end
        end
    endfunction

    task automatic set_slot(input int i, input int addr, input int data);
        ra[i*5 +: 5] = 5'(addr);
        rd[i*4 +: 4] = 4'(data);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        rwe = 4'b1111;
        ra  = 20'hABCDE;
        rd  = 16'hFFFF;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        checks++;
        if ({ce0, ce1, we0, we1} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {ce0, ce1, we0, we1}); end
        checks++;
        if ({a0, a1, d0, d1} !== 18'd0) begin errors++; $display("FAIL reset_addr_data got %h want 0", {a0, a1, d0, d1}); end
        checks++;
        if ({rvalid, rq} !== 20'd0) begin errors++; $display("FAIL reset_rvalid_rq got %h want 0", {rvalid, rq}); end
        checks++;
        if ({wem0, wem1} !== 8'hFF) begin errors++; $display("FAIL wem got %h want ff", {wem0, wem1}); end
        req = 4'b0000;
        rwe = 4'b0000;
        rd  = 16'h0000;
        rst = 1'b0;
        reload_model();
        @(negedge clk);
    endtask

    task automatic test_all_reads();
        req = 4'b1111; rwe = 4'b0000;
        set_slot(0, 3, 0); set_slot(1, 7, 0); set_slot(2, 11, 0); set_slot(3, 15, 0);
        #1;
        checks++;
        if (gnt !== 4'b0011) begin errors++; $display("FAIL all_reads_gnt0 got %b want 0011", gnt); end
        checks++;
        if ({ce0, ce1, we0, we1, a0, a1} !== {4'b1100, 5'd3, 5'd7}) begin
            errors++; $display("FAIL all_reads_ports0 got ce%b%b we%b%b a0=%0d a1=%0d want ce11 we00 a0=3 a1=7", ce0, ce1, we0, we1, a0, a1);
        end
        @(negedge clk);
        req = 4'b1100;
        #1;
        checks++;
        if (gnt !== 4'b1100) begin errors++; $display("FAIL all_reads_gnt1 got %b want 1100", gnt); end
        checks++;
        if ({a0, a1} !== {5'd11, 5'd15}) begin errors++; $display("FAIL all_reads_ports1 got a0=%0d a1=%0d want 11 15", a0, a1); end
        checks++;
        if ({rvalid, rq} !== {4'b0011, 8'h00, mem_m[7], mem_m[3]}) begin
            errors++; $display("FAIL all_reads_ret0 got rv=%b rq=%h want rv=0011 rq=%h", rvalid, rq, {8'h00, mem_m[7], mem_m[3]});
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        checks++;
        if ({rvalid, rq} !== {4'b1100, mem_m[15], mem_m[11], 8'h00}) begin
            errors++; $display("FAIL all_reads_ret1 got rv=%b rq=%h want rv=1100 rq=%h", rvalid, rq, {mem_m[15], mem_m[11], 8'h00});
        end
        @(negedge clk);
    endtask

    task automatic test_conflict();
        req = 4'b0011; rwe = 4'b0001;
        set_slot(0, 5, 'hA); set_slot(1, 5, 'h3);
        #1;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL conflict_gnt got %b want 0001", gnt); end
        checks++;
        if ({ce0, we0, a0, d0, ce1} !== {2'b11, 5'd5, 4'hA, 1'b0}) begin
            errors++; $display("FAIL conflict_ports got ce0=%b we0=%b a0=%0d d0=%h ce1=%b want 1 1 5 a 0", ce0, we0, a0, d0, ce1);
        end
        mem_m[5] = 4'hA;
        @(negedge clk);
        req = 4'b0010;
        #1;
        checks++;
        if ({gnt, ce0, we0, a0, d0, ce1} !== {4'b0010, 2'b10, 5'd5, 4'h0, 1'b0}) begin
            errors++; $display("FAIL conflict_retry got gnt=%b ce0=%b we0=%b a0=%0d d0=%h ce1=%b want 0010 1 0 5 0 0", gnt, ce0, we0, a0, d0, ce1);
        end
        checks++;
        if (rvalid !== 4'b0000) begin errors++; $display("FAIL conflict_write_rvalid got %b want 0000", rvalid); end
        @(negedge clk);
        req = 4'b0000;
        #1;
        checks++;
        if ({rvalid, rq} !== {4'b0010, 16'h00A0}) begin
            errors++; $display("FAIL conflict_readback got rv=%b rq=%h want rv=0010 rq=00a0", rvalid, rq);
        end
        @(negedge clk);
    endtask

    task automatic test_skip();
        req = 4'b1000; rwe = 4'b0000;
        set_slot(3, 0, 0);
        #1;
        checks++;
        if (gnt !== 4'b1000) begin errors++; $display("FAIL skip_setup_gnt got %b want 1000", gnt); end
        @(negedge clk);
        req = 4'b0111; rwe = 4'b0011;
        set_slot(0, 9, 'h6); set_slot(1, 9, 'hC); set_slot(2, 2, 'h5);
        #1;
        checks++;
        if (gnt !== 4'b0101) begin errors++; $display("FAIL skip_gnt got %b want 0101", gnt); end
        checks++;
        if ({ce0, we0, a0, d0, ce1, we1, a1, d1} !== {2'b11, 5'd9, 4'h6, 2'b10, 5'd2, 4'h0}) begin
            errors++; $display("FAIL skip_ports got p0=%b/%b/%0d/%h p1=%b/%b/%0d/%h want 1/1/9/6 1/0/2/0", ce0, we0, a0, d0, ce1, we1, a1, d1);
        end
        mem_m[9] = 4'h6;
        @(negedge clk);
        req = 4'b0000; rwe = 4'b0000;
        #1;
        checks++;
        if ({rvalid, rq} !== {4'b0100, 4'h0, mem_m[2], 8'h00}) begin
            errors++; $display("FAIL skip_ret got rv=%b rq=%h want rv=0100 rq=%h", rvalid, rq, {4'h0, mem_m[2], 8'h00});
        end
        @(negedge clk);
    endtask

    task automatic test_same_read();
        // P is 3 here: a lone R1 grant moves it to 2.
        req = 4'b0010; rwe = 4'b0000;
        set_slot(1, 0, 0);
        @(negedge clk);
        req = 4'b1100;
        set_slot(2, 12, 0); set_slot(3, 12, 0);
        #1;
        checks++;
        if ({gnt, ce0, ce1, we0, we1, a0, a1} !== {4'b1100, 4'b1100, 5'd12, 5'd12}) begin
            errors++; $display("FAIL same_read_grant got gnt=%b ce%b%b we%b%b a0=%0d a1=%0d want 1100 ce11 we00 12 12", gnt, ce0, ce1, we0, we1, a0, a1);
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        checks++;
        if ({rvalid, rq} !== {4'b1100, mem_m[12], mem_m[12], 8'h00}) begin
            errors++; $display("FAIL same_read_ret got rv=%b rq=%h want rv=1100 rq=%h", rvalid, rq, {mem_m[12], mem_m[12], 8'h00});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        rwe = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            req = (n < 3) ? 4'b0100 : 4'b0000;
            set_slot(2, 20 + n, 0);
            #1;
            checks++;
            if (gnt !== ((n < 3) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL b2b_gnt%0d got %b", n, gnt); end
            checks++;
            if ({rvalid, rq} !== ((n > 0) ? {4'b0100, 4'h0, mem_m[20 + n - 1], 8'h00} : 20'd0)) begin
                errors++; $display("FAIL b2b_ret%0d got rv=%b rq=%h want mem=%h", n, rvalid, rq, mem_m[20 + n - 1]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_kill();
        req = 4'b0001; rwe = 4'b0000;
        set_slot(0, 4, 0);
        #1;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL kill_gnt got %b want 0001", gnt); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({gnt, ce0, ce1, we0, we1} !== 8'd0) begin errors++; $display("FAIL kill_rst_ctrl got gnt=%b ce%b%b we%b%b want all 0", gnt, ce0, ce1, we0, we1); end
        @(negedge clk);
        #1;
        checks++;
        if ({rvalid, rq, gnt, ce0, ce1} !== 26'd0) begin
            errors++; $display("FAIL kill_rvalid got rv=%b rq=%h gnt=%b ce%b%b want all 0", rvalid, rq, gnt, ce0, ce1);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;
        reload_model();
        @(negedge clk);
        req = 4'b1111;
        set_slot(0, 3, 0); set_slot(1, 7, 0); set_slot(2, 11, 0); set_slot(3, 15, 0);
        #1;
        checks++;
        if (gnt !== 4'b0011) begin errors++; $display("FAIL kill_ptr got %b want 0011", gnt); end
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic        preq [4];
        logic        pwe  [4];
        int          paddr[4];
        int          pdata[4];
        logic [3:0]  exp_rv, nrv;
        logic [15:0] exp_rq, nrq;
        int          w0, w1, win;
        logic [10:0] exp_p0, exp_p1;

        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        reload_model();
        exp_rv = '0;
        exp_rq = '0;
        for (int i = 0; i < 4; i++) begin
            preq[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = 0; pdata[i] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!preq[i] && $urandom_range(0, 1) == 1) begin
                    preq[i]  = 1'b1;
                    pwe[i]   = 1'($urandom_range(0, 1));
                    paddr[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
                    pdata[i] = int'($urandom_range(0, 15));
                end
                req[i] = preq[i];
                rwe[i] = pwe[i];
                set_slot(i, paddr[i], pdata[i]);
            end
            #1;
            model_arb(req, rwe, ra, p_m, w0, w1);
            checks++;
            if (gnt !== (((w0 >= 0) ? 4'(1 << w0) : 4'b0) | ((w1 >= 0) ? 4'(1 << w1) : 4'b0))) begin
                errors++; $display("FAIL rand_gnt cyc %0d got %b want winners %0d,%0d", cyc, gnt, w0, w1);
            end
            exp_p0 = (w0 >= 0) ? {1'b1, pwe[w0], 5'(paddr[w0]), pwe[w0] ? 4'(pdata[w0]) : 4'h0} : 11'd0;
            exp_p1 = (w1 >= 0) ? {1'b1, pwe[w1], 5'(paddr[w1]), pwe[w1] ? 4'(pdata[w1]) : 4'h0} : 11'd0;
            checks++;
            if ({ce0, we0, a0, d0} !== exp_p0) begin errors++; $display("FAIL rand_port0 cyc %0d got %h want %h", cyc, {ce0, we0, a0, d0}, exp_p0); end
            checks++;
            if ({ce1, we1, a1, d1} !== exp_p1) begin errors++; $display("FAIL rand_port1 cyc %0d got %h want %h", cyc, {ce1, we1, a1, d1}, exp_p1); end
            checks++;
            if ({rvalid, rq} !== {exp_rv, exp_rq}) begin
                errors++; $display("FAIL rand_return cyc %0d got rv=%b rq=%h want rv=%b rq=%h", cyc, rvalid, rq, exp_rv, exp_rq);
            end
            if (ce0 && ce1) begin
                checks++;
                if (a0 == a1 && (we0 || we1)) begin errors++; $display("FAIL rand_hazard cyc %0d got a=%0d we%b%b want no write collision", cyc, a0, we0, we1); end
            end
            nrv = '0;
            nrq = '0;
            for (int s = 0; s < 2; s++) begin
                win = (s == 0) ? w0 : w1;
                if (win >= 0 && !pwe[win]) begin
                    nrv[win]          = 1'b1;
                    nrq[win*4 +: 4]   = mem_m[paddr[win]];
                end
            end
            for (int s = 0; s < 2; s++) begin
                win = (s == 0) ? w0 : w1;
                if (win >= 0) begin
                    if (pwe[win]) mem_m[paddr[win]] = 4'(pdata[win]);
                    preq[win] = 1'b0;
                end
            end
            if (w1 >= 0)      p_m = (w1 + 1) % 4;
            else if (w0 >= 0) p_m = (w0 + 1) % 4;
            @(negedge clk);
            exp_rv = nrv;
            exp_rq = nrq;
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req = '0; rwe = '0; ra = '0; rd = '0;
        reload_model();
        @(negedge clk);
        test_reset();
        test_all_reads();
        test_conflict();
        test_skip();
        test_same_read();
        test_back_to_back();
        test_reset_kill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
